// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int XLEN       = 32;
    localparam int INST_WIDTH = 32;
    localparam int PC_STEP    = 4;

    localparam logic [XLEN-1:0]       RESET_PC_DEFAULT = '0;
    localparam logic [INST_WIDTH-1:0] NOP_INST         = 32'h0000_0013;

    typedef struct packed {
        logic [INST_WIDTH-1:0] instr;
        logic [XLEN-1:0]       pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(PC_STEP);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: memory request/response, instruction delivery, redirect and fault.
interface fetch_unit_if;
    import fetch_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic [XLEN-1:0]       req_addr;
    logic                  resp_valid;
    logic [INST_WIDTH-1:0] resp_data;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [INST_WIDTH-1:0] inst_data;
    logic [XLEN-1:0]       inst_pc;
    logic                  redirect_valid;
    logic [XLEN-1:0]       redirect_pc;
    logic                  fetch_fault;

    modport master (
        output req_valid, req_addr, inst_valid, inst_data, inst_pc, fetch_fault,
        input  req_ready, resp_valid, resp_data, inst_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  req_valid, req_addr, inst_valid, inst_data, inst_pc, fetch_fault,
        output req_ready, resp_valid, resp_data, inst_ready, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/fetch_queue.sv
// Power-of-two synchronous FIFO of {instr, pc} entries with a single-cycle flush.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  fetch_entry_t           i_data,
    input  logic                   i_pop,
    output fetch_entry_t           o_head,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_occ
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    fetch_entry_t r_mem [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    // The extra pointer bit tells full from empty when the index bits match.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push && !w_full && !i_flush;
    assign w_do_pop  = i_pop && !w_empty && !i_flush;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= r_wr_ptr;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the empty check below keeps stale entries off the outputs.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty = w_empty;
    assign o_occ   = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues word reads, queues tagged replies, flushes on redirect.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int              QUEUE_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop_cnt;

    logic [CW-1:0]   w_occ;
    logic            w_empty;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_entry;
    logic [CW:0]     w_inflight;
    logic            w_redirect;
    logic [XLEN-1:0] w_redir_target;
    logic            w_fault;
    logic            w_req_valid;
    logic            w_req_fire;
    logic            w_resp_ok;
    logic            w_push;
    logic            w_pop;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_fault;
    logic w_misaligned;

    assign w_redir_target = bus.redirect_pc;
    assign w_misaligned   = (bus.redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (!reset)                          r_fault <= 1'b0;
        else if (w_redirect && w_misaligned) r_fault <= 1'b1;
    end

    assign w_fault = r_fault;
`else
    assign w_redir_target = bus.redirect_pc & ~XLEN'(3);
    assign w_fault        = 1'b0;
`endif

    assign w_redirect = bus.redirect_valid;

    // Counting in-flight words against free slots guarantees every reply has room.
    assign w_inflight  = {1'b0, w_occ} + {1'b0, r_outstanding};
    assign w_req_valid = reset && !w_fault && !w_redirect &&
                         (w_inflight < (CW+1)'(QUEUE_DEPTH));
    assign w_req_fire  = w_req_valid && bus.req_ready;
    assign w_resp_ok   = bus.resp_valid && (r_outstanding != '0);
    assign w_push      = w_resp_ok && (r_drop_cnt == '0) && !w_redirect;
    assign w_pop       = !w_empty && bus.inst_ready;

    assign w_push_entry = '{instr: bus.resp_data, pc: r_resp_pc};

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .i_flush (w_redirect),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_occ   (w_occ)
    );

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_resp_ok);
            if (w_redirect) begin
                // Every word still in flight belongs to the old path.
                r_fetch_pc <= w_redir_target;
                r_resp_pc  <= w_redir_target;
                r_drop_cnt <= r_outstanding - CW'(w_resp_ok);
            end else begin
                if (w_req_fire) r_fetch_pc <= next_pc(r_fetch_pc);
                if (w_push)     r_resp_pc  <= next_pc(r_resp_pc);
                if (w_resp_ok && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - CW'(1);
            end
        end
    end

    assign bus.req_valid   = w_req_valid;
    assign bus.req_addr    = r_fetch_pc;
    assign bus.inst_valid  = !w_empty;
    assign bus.inst_data   = w_head.instr;
    assign bus.inst_pc     = w_head.pc;
    assign bus.fetch_fault = w_fault;

endmodule
